meas_vector_streamer: RTL and testbench
=======================================

Name: meas_vector_streamer

Overview:
- Sits directly downstream of the test-image measurement source in the compressed-sensing reconstruction chain.
- Captures the full parallel measurement vector (MEAS_NUM words of MEAS_WIDTH bits) on a load strobe and holds it in a local register bank.
- Streams the words one per beat over a valid/ready interface to the reconstruction engine.
- Flags loads that arrive while a stream is still in progress.

Parameters:
- MEAS_NUM, 48, number of measurements per vector.
- MEAS_WIDTH, 16, bits per measurement; two's-complement signed.
- IDX_WIDTH, 6, width of the beat index; must satisfy 2^IDX_WIDTH >= MEAS_NUM.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- meas_in  input  MEAS_NUM*MEAS_WIDTH  flattened vector; word k is at bits [k*MEAS_WIDTH +: MEAS_WIDTH].
- meas_load  input  1  one-cycle strobe; meas_in is valid in that cycle.
- out_valid  output  1  out_data, out_index and out_last are valid.
- out_ready  input  1  downstream accepts the current beat.
- out_data  output  MEAS_WIDTH  current measurement word.
- out_index  output  IDX_WIDTH  index of the current word, 0..MEAS_NUM-1.
- out_last  output  1  current beat is word MEAS_NUM-1.
- busy  output  1  high in the STREAM state.
- done  output  1  one-cycle pulse after the last beat is accepted.
- overrun  output  1  sticky; set by a dropped load.
- overrun_clr  input  1  clears overrun.

Behaviour:
- Clock and reset (already decided): one clock; reset is asynchronous and active-high. Port names are clk and reset.
- Reset values: every output is 0; state is IDLE; the register bank is cleared to 0. Reset asserted mid-stream aborts immediately: out_valid drops asynchronously and no done pulse is produced.
- States: IDLE and STREAM.
- IDLE:
  - meas_load=1 at an edge: capture all MEAS_NUM words into the bank, set index to 0, go to STREAM.
  - From the next cycle: out_valid=1, busy=1, out_data=word 0.
  - Load-to-first-valid latency is 1 cycle.
- STREAM:
  - A beat transfers at an edge with out_valid and out_ready both high.
  - On a transfer with index < MEAS_NUM-1: increment index; out_data shows the next word in the following cycle.
  - While out_valid=1 and out_ready=0: out_data, out_index and out_last hold stable.
  - out_valid never deasserts before a transfer.
  - out_last = (index == MEAS_NUM-1).
  - Transfer with out_last=1: go to IDLE; the next cycle has out_valid=0, busy=0, done=1 for exactly one cycle.
  - Sustained out_ready=1 gives one beat per cycle, MEAS_NUM cycles total.
- Outputs are registered or decoded from registered state only; there is no combinational path from out_ready to out_valid.
- Dropped loads: meas_load=1 in STREAM (including the cycle of the final transfer) is ignored. The bank is unchanged and overrun is set at that edge.
- Re-load: a load in the done cycle (state already IDLE) is accepted normally. Back-to-back vectors therefore cost 1 idle cycle.
- overrun_clr:
  - Clears overrun at the edge.
  - If a drop and overrun_clr occur at the same edge, set wins.
- meas_load held high across many cycles: treated as one load per IDLE entry. The next load is captured in the done cycle.
- The bank stays readable after done: out_data holds the last word and is don't-care while out_valid=0.

Optional Feature:
- Macro: MEAS_ENERGY_EN.
- When defined, these ports and logic are added:
  - Output energy, width 2*MEAS_WIDTH+IDX_WIDTH: unsigned sum of squares of the signed words. This is the initial residual norm squared for the solver.
  - Output energy_valid, width 1.
- Energy behaviour:
  - The accumulator clears on an accepted load.
  - It adds out_data*out_data (signed multiply, zero-extended result) on each transfer.
  - energy_valid pulses coincident with done; energy holds until the next accepted load.
  - Reset sets both outputs to 0.
- When the macro is undefined, the ports and logic are absent and the remaining behaviour is identical.

Test Plan:
- Reset-mid-stream: reset pulses while at index 10 -> outputs go to 0 without waiting for a clock edge, no done pulse; a subsequent load streams from index 0.
- Load words 0..47 = 16'h0001..16'h0030, out_ready tied 1 -> out_valid rises 1 cycle after load; 48 consecutive beats carrying 0x0001..0x0030; out_last only on index 47; done on the cycle after.
- Same load, out_ready toggling 1,0,0,1 repeating -> no word skipped or repeated; out_data holds across ready=0 cycles; 48 transfers total.
- meas_load pulsed at index 20 with different data -> streamed words unchanged, overrun=1; overrun_clr pulse -> overrun=0; overrun_clr in the same cycle as a new drop -> overrun stays 1.
- Load in the done cycle -> accepted; out_valid reasserts the next cycle with the new word 0.
- MEAS_ENERGY_EN, words all 16'h8000 -> energy = 48*2^30 = 0xC_0000_0000 with energy_valid concurrent with done; words alternating 16'hFFFF/16'h0002 -> energy = 24*1 + 24*4 = 120.

Source files
------------

// File: rtl/meas_vector_streamer.sv
// rtl/meas_vector_streamer.sv - captures a parallel measurement vector and streams it word by word
// Optional feature macro: MEAS_ENERGY_EN adds the energy / energy_valid outputs (sum of squared words).
module meas_vector_streamer #(
  parameter int MEAS_NUM   = 48,
  parameter int MEAS_WIDTH = 16,
  parameter int IDX_WIDTH  = 6
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [MEAS_NUM*MEAS_WIDTH-1:0] meas_in,
  input  logic                           meas_load,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [MEAS_WIDTH-1:0]          out_data,
  output logic [IDX_WIDTH-1:0]           out_index,
  output logic                           out_last,
  output logic                           busy,
  output logic                           done,
  output logic                           overrun,
  input  logic                           overrun_clr
`ifdef MEAS_ENERGY_EN
  ,
  output logic [2*MEAS_WIDTH+IDX_WIDTH-1:0] energy,
  output logic                              energy_valid
`endif
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(MEAS_NUM - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                state;
  state_t                next_state;
  logic [MEAS_WIDTH-1:0] bank [MEAS_NUM];
  logic [IDX_WIDTH-1:0]  index;
  logic                  accept;
  logic                  drop;
  logic                  xfer;
  logic                  at_last;

  // Loads are only honoured in IDLE; any load seen while streaming is a drop.
  assign accept  = (state == IDLE) && meas_load;
  assign drop    = (state == STREAM) && meas_load;
  assign xfer    = (state == STREAM) && out_ready;
  assign at_last = (index == LAST_IDX);

  // All outputs decode from registered state, so out_ready never reaches out_valid combinationally.
  assign out_valid = (state == STREAM);
  assign busy      = (state == STREAM);
  assign out_last  = (state == STREAM) && at_last;
  assign out_index = index;
  assign out_data  = bank[index];

  // State register; async reset aborts any stream in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (meas_load) next_state = STREAM;
      STREAM:  if (out_ready && at_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Register bank: captured whole on an accepted load, untouched otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < MEAS_NUM; k++) bank[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < MEAS_NUM; k++) bank[k] <= meas_in[k*MEAS_WIDTH +: MEAS_WIDTH];
    end
  end

  // Beat index: restarts on load, advances per transfer, parks on the last word after done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                index <= '0;
    else if (accept)          index <= '0;
    else if (xfer && !at_last) index <= index + 1'b1;
  end

  // Done pulses in the cycle after the final beat is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) done <= 1'b0;
    else       done <= xfer && at_last;
  end

  // Sticky overrun flag; a drop at the same edge as a clear keeps it set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            overrun <= 1'b0;
    else if (drop)        overrun <= 1'b1;
    else if (overrun_clr) overrun <= 1'b0;
  end

`ifdef MEAS_ENERGY_EN
  logic signed [MEAS_WIDTH-1:0]   word_s;
  logic signed [2*MEAS_WIDTH-1:0] square;

  assign word_s = out_data;
  assign square = (2*MEAS_WIDTH)'(word_s) * (2*MEAS_WIDTH)'(word_s);

  // Energy accumulator: cleared on load, sums squares of transferred words, holds after done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       energy <= '0;
    else if (accept) energy <= '0;
    else if (xfer)   energy <= energy + (2*MEAS_WIDTH+IDX_WIDTH)'($unsigned(square));
  end

  // Energy valid strobes alongside done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) energy_valid <= 1'b0;
    else       energy_valid <= xfer && at_last;
  end
`endif

endmodule

// File: tb/tb_meas_vector_streamer.sv
// tb/tb_meas_vector_streamer.sv - scoreboard bench for meas_vector_streamer
module tb_meas_vector_streamer;

  localparam int MN = 48;
  localparam int MW = 16;
  localparam int IW = 6;
  localparam int EW = 2*MW + IW;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [MN*MW-1:0]     meas_in;
  logic                 meas_load;
  logic                 out_valid;
  logic                 out_ready;
  logic [MW-1:0]        out_data;
  logic [IW-1:0]        out_index;
  logic                 out_last;
  logic                 busy;
  logic                 done;
  logic                 overrun;
  logic                 overrun_clr;
`ifdef MEAS_ENERGY_EN
  logic [EW-1:0]        energy;
  logic                 energy_valid;
`endif

  int errors = 0;
  int checks = 0;
  int xfer_cnt = 0;

  logic [MW+IW:0] exp_q[$];
  logic [EW-1:0]  en_q[$];

  logic [MN*MW-1:0] va, vb, vc, v8, valt;

  meas_vector_streamer #(.MEAS_NUM(MN), .MEAS_WIDTH(MW), .IDX_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .meas_in(meas_in), .meas_load(meas_load),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy), .done(done),
    .overrun(overrun), .overrun_clr(overrun_clr)
`ifdef MEAS_ENERGY_EN
    , .energy(energy), .energy_valid(energy_valid)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive a load now, push the expected beats and energy, release after the next edge.
  task automatic do_load(input logic [MN*MW-1:0] v);
    logic [EW-1:0] e;
    logic [MW-1:0] w;
    int            ws;
    e = '0;
    meas_in   = v;
    meas_load = 1'b1;
    for (int k = 0; k < MN; k++) begin
      w  = v[k*MW +: MW];
      ws = $signed(w);
      e  = e + EW'(ws * ws);
      exp_q.push_back({w, IW'(k), (k == MN-1)});
    end
    en_q.push_back(e);
    @(posedge clk); #1;
    meas_load = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    if (n >= 400) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_index(input logic [IW-1:0] idx);
    int n;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (out_valid && out_index == idx) break;
      n++;
    end
    if (n >= 200) chk("index_timeout", 0, 1);
  endtask

  // Monitor: compares every accepted beat against the scoreboard, checks hold and done timing.
  initial begin
    logic           exp_done;
    logic           hold_pending;
    logic [MW+IW:0] held;
    logic [MW+IW:0] cur;
    logic [MW+IW:0] e;
    exp_done     = 1'b0;
    hold_pending = 1'b0;
    held         = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_done     = 1'b0;
        hold_pending = 1'b0;
      end else begin
        chk("done_timing", done, exp_done);
`ifdef MEAS_ENERGY_EN
        chk("energy_valid", energy_valid, exp_done);
        if (exp_done && en_q.size() != 0) chk("energy", energy, en_q.pop_front());
`endif
        exp_done = 1'b0;
        cur = {out_data, out_index, out_last};
        if (out_valid) begin
          if (hold_pending) chk("hold", cur, held);
          if (out_ready) begin
            hold_pending = 1'b0;
            if (exp_q.size() == 0) begin
              chk("beat_unexpected", cur, '0);
            end else begin
              e = exp_q.pop_front();
              chk("beat", cur, e);
              xfer_cnt++;
              if (e[0]) exp_done = 1'b1;
            end
          end else begin
            hold_pending = 1'b1;
            held         = cur;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < MN; k++) begin
      va[k*MW +: MW]   = MW'(k + 1);
      vb[k*MW +: MW]   = MW'(16'hA500 + k);
      vc[k*MW +: MW]   = MW'(16'hFF00 - k);
      v8[k*MW +: MW]   = 16'h8000;
      valt[k*MW +: MW] = (k % 2 == 0) ? 16'hFFFF : 16'h0002;
    end
    reset = 1'b1; meas_in = '0; meas_load = 1'b0; out_ready = 1'b0; overrun_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_data", out_data, 0);
    chk("rst_index", out_index, 0);
    chk("rst_last", out_last, 0);
    @(negedge clk); #2;
    reset = 1'b0;

    // Streaming at full rate, with exact latency and duration.
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_valid", out_valid, 0);
    do_load(va);
    chk("lat_valid", out_valid, 1);
    chk("lat_busy", busy, 1);
    chk("lat_index", out_index, 0);
    chk("lat_data", out_data, 16'h0001);
    repeat (47) @(posedge clk);
    #1;
    chk("last_flag", out_last, 1);
    chk("last_data", out_data, 16'h0030);
    @(posedge clk); #1;
    chk("end_done", done, 1);
    chk("end_valid", out_valid, 0);
    chk("end_busy", busy, 0);
    chk("end_data_hold", out_data, 16'h0030);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);

    // Ready pattern 1,0,0,1.
    xfer_cnt = 0;
    do_load(va);
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) break;
      out_ready = (c % 4 == 0) || (c % 4 == 3);
    end
    out_ready = 1'b1;
    wait_done();
    chk("xfer_count", xfer_cnt, MN);

    // Reset mid-stream.
    @(posedge clk); #1;
    do_load(va);
    wait_index(10);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_index", out_index, 0);
    chk("arst_data", out_data, 0);
    exp_q.delete();
    en_q.delete();
    @(posedge clk); #1;
    chk("arst_done", done, 0);
    @(negedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #1;
    do_load(vc);
    chk("post_rst_index", out_index, 0);
    chk("post_rst_data", out_data, 16'hFF00);
    wait_done();

    // Dropped loads and overrun handling.
    @(posedge clk); #1;
    do_load(va);
    wait_index(20);
    #2;
    meas_in = vb; meas_load = 1'b1;
    @(posedge clk); #1;
    meas_load = 1'b0;
    chk("ovr_set", overrun, 1);
    overrun_clr = 1'b1;
    @(posedge clk); #1;
    overrun_clr = 1'b0;
    chk("ovr_clr", overrun, 0);
    chk("ovr_still_busy", busy, 1);
    meas_load = 1'b1; overrun_clr = 1'b1;
    @(posedge clk); #1;
    meas_load = 1'b0; overrun_clr = 1'b0;
    chk("ovr_set_wins", overrun, 1);
    overrun_clr = 1'b1;
    @(posedge clk); #1;
    overrun_clr = 1'b0;
    wait_done();

    // Load in the done cycle is accepted.
    @(posedge clk); #1;
    do_load(va);
    wait_done();
    #2;
    do_load(vc);
    chk("reload_valid", out_valid, 1);
    chk("reload_data", out_data, 16'hFF00);
    chk("reload_no_ovr", overrun, 0);
    wait_done();

`ifdef MEAS_ENERGY_EN
    @(posedge clk); #1;
    do_load(v8);
    wait_done();
    chk("energy_8000", energy, 38'hC_0000_0000);
    chk("energy_8000_valid", energy_valid, 1);
    @(posedge clk); #1;
    do_load(valt);
    wait_done();
    chk("energy_alt", energy, 120);
`endif

    repeat (3) @(posedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
